// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter.
// Presents one byte at a time on tx_data with a clean 0->1 tx_start edge,
// holds both until the transmitter's clear_req, then waits a gap before re-arming.
module uart_tx_feeder #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AW         = 3,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          clear_req,
  input  logic          busy
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARM      = 2'd1,
    S_WAIT_CLR = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [GW-1:0]   gap_cnt;
  logic [LW-1:0]   level_nxt_c;
  logic            push_c;
  logic            pop_c;

  // Push when there is room; pop only from IDLE when a frame may be launched.
  assign push_c = wr_en && !full;
  assign pop_c  = (state == S_IDLE) && !empty && enable && !busy;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_nxt_c = level;
    if (push_c && !pop_c) begin
      level_nxt_c = level + LW'(1);
    end else if (!push_c && pop_c) begin
      level_nxt_c = level - LW'(1);
    end
  end

  // Storage array; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy flags and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_nxt_c;
      full  <= (level_nxt_c == LW'(DEPTH));
      empty <= (level_nxt_c == '0);
      // A new overflow event takes priority over a clear on the same edge.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Launch sequencer: data is loaded one cycle before tx_start rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      gap_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx_start <= 1'b0;
          if (pop_c) begin
            tx_data <= mem[rd_ptr];
            state   <= S_ARM;
          end
        end
        S_ARM: begin
          tx_start <= 1'b1;
          state    <= S_WAIT_CLR;
        end
        S_WAIT_CLR: begin
          if (clear_req) begin
            tx_start <= 1'b0;
            gap_cnt  <= '0;
            state    <= S_GAP;
          end
        end
        S_GAP: begin
          tx_start <= 1'b0;
          gap_cnt  <= gap_cnt + GW'(1);
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= S_IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small 4-clk/bit transmitter model.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned AW         = 3;
  localparam int unsigned GAP_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        ovf_clr = 1'b0;
  logic        man_clear = 1'b0;
  logic        man_busy = 1'b0;
  logic        auto_tx = 1'b0;
  logic        full, empty, overflow, tx_start, clear_req, busy;
  logic [AW:0] level;
  logic [7:0]  tx_data;

  // transmitter model state
  logic        sync1, sync2, m_active, m_clear, m_busy, line;
  logic [1:0]  m_cnt;
  logic [3:0]  m_bit;
  logic [7:0]  m_shift;
  logic        line_q [$];
  logic [7:0]  sent_q [$];
  int          gap_q  [$];
  int          low_run = 0;

  int total = 0;
  int bad   = 0;

  assign clear_req = auto_tx ? m_clear : man_clear;
  assign busy      = auto_tx ? m_busy  : man_busy;

  uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow), .ovf_clr(ovf_clr),
    .tx_start(tx_start), .tx_data(tx_data), .clear_req(clear_req), .busy(busy)
  );

  always #5 clk = ~clk;

  // Transmitter: 2-flop rising-edge detect, start/8 data LSB first/stop at 4 clk per bit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0; sync2 <= 1'b0; m_active <= 1'b0; m_clear <= 1'b0;
      m_busy <= 1'b0; line <= 1'b1; m_cnt <= 2'd0; m_bit <= 4'd0; m_shift <= 8'h00;
    end else begin
      sync1   <= tx_start;
      sync2   <= sync1;
      m_clear <= 1'b0;
      if (!m_active) begin
        if (auto_tx && sync1 && !sync2) begin
          m_active <= 1'b1; m_busy <= 1'b1; m_cnt <= 2'd0; m_bit <= 4'd0; line <= 1'b0;
        end
      end else begin
        if (m_cnt == 2'd1) begin
          line_q.push_back(line);
          if (m_bit >= 4'd1 && m_bit <= 4'd8) m_shift[3'(m_bit - 4'd1)] <= line;
        end
        if (m_cnt == 2'd3) begin
          m_cnt <= 2'd0;
          if (m_bit == 4'd9) begin
            m_active <= 1'b0; m_busy <= 1'b0; m_clear <= 1'b1; line <= 1'b1;
            sent_q.push_back(m_shift);
          end else begin
            m_bit <= m_bit + 4'd1;
            line  <= (m_bit == 4'd8) ? 1'b1 : tx_data[m_bit[2:0]];
          end
        end else begin
          m_cnt <= m_cnt + 2'd1;
        end
      end
    end
  end

  // Length of each low run of tx_start preceding a rise.
  always @(negedge clk) begin
    if (!tx_start) low_run = low_run + 1;
    else begin
      if (low_run > 0) gap_q.push_back(low_run);
      low_run = 0;
    end
  end

  task automatic push(input logic [7:0] d);
    wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic man_frame(output logic [7:0] d, output bit ok);
    ok = 1'b0; d = 8'h00;
    for (int i = 0; i < 50 && !tx_start; i++) @(negedge clk);
    if (tx_start) begin
      d = tx_data; man_clear = 1'b1;
      @(negedge clk);
      man_clear = 1'b0;
      @(negedge clk);
      ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 6;
    if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame;
    int ls, ss;
    logic [9:0] got_line;
    logic [9:0] exp_line;
    exp_line = 10'b1101001010;
    auto_tx = 1'b1; enable = 1'b1;
    ls = line_q.size(); ss = sent_q.size();
    push(8'hA5);
    total += 2;
    if (level !== 4'd1) begin bad++; $display("FAIL single_level_t got=%0d exp=1", level); end
    if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_t got=%b exp=0", tx_start); end
    @(negedge clk);
    total += 3;
    if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_t1 got=%b exp=0", tx_start); end
    if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_data_t1 got=%h exp=a5", tx_data); end
    if (level !== 4'd0) begin bad++; $display("FAIL single_level_t1 got=%0d exp=0", level); end
    @(negedge clk);
    total++;
    if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start_t2 got=%b exp=1", tx_start); end
    for (int i = 0; i < 200 && sent_q.size() == ss; i++) @(negedge clk);
    total++;
    if (sent_q.size() == ss) begin
      bad++; $display("FAIL single_timeout frames got=0 exp=1");
    end else begin
      total += 4;
      if (line_q.size() < ls + 10) begin
        bad++; $display("FAIL single_line_count got=%0d exp=10", line_q.size() - ls);
      end else begin
        for (int i = 0; i < 10; i++) got_line[i] = line_q[ls + i];
        if (got_line !== exp_line) begin bad++; $display("FAIL single_line got=%b exp=%b", got_line, exp_line); end
      end
      if (sent_q[ss] !== 8'hA5) begin bad++; $display("FAIL single_byte got=%h exp=a5", sent_q[ss]); end
      if (tx_start !== 1'b1) begin bad++; $display("FAIL single_hold got=%b exp=1", tx_start); end
      @(negedge clk);
      if (tx_start !== 1'b0) begin bad++; $display("FAIL single_fall got=%b exp=0", tx_start); end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_overflow_order;
    int ss, gs;
    enable = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    total += 3;
    if (level !== 4'd8) begin bad++; $display("FAIL fill_level got=%0d exp=8", level); end
    if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf got=%b exp=0", overflow); end
    push(8'hFF);
    total += 2;
    if (overflow !== 1'b1) begin bad++; $display("FAIL drop_ovf got=%b exp=1", overflow); end
    if (level !== 4'd8) begin bad++; $display("FAIL drop_level got=%0d exp=8", level); end
    ss = sent_q.size(); gs = gap_q.size();
    enable = 1'b1;
    for (int i = 0; i < 1000 && sent_q.size() < ss + 8; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    total++;
    if (sent_q.size() != ss + 8) begin
      bad++; $display("FAIL order_count got=%0d exp=8", sent_q.size() - ss);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (sent_q[ss + i] !== 8'(i + 1))
          begin bad++; $display("FAIL order_byte%0d got=%h exp=%h", i, sent_q[ss + i], 8'(i + 1)); end
      end
    end
    total++;
    if (gap_q.size() < gs + 8) begin
      bad++; $display("FAIL gap_count got=%0d exp=8", gap_q.size() - gs);
    end else begin
      for (int i = 1; i < 8; i++) begin
        total++;
        if (gap_q[gs + i] != GAP_CYCLES + 2)
          begin bad++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, gap_q[gs + i], GAP_CYCLES + 2); end
      end
    end
    total += 2;
    if (empty !== 1'b1) begin bad++; $display("FAIL order_empty got=%b exp=1", empty); end
    if (level !== 4'd0) begin bad++; $display("FAIL order_level got=%0d exp=0", level); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL order_ovf_clr got=%b exp=0", overflow); end
  endtask

  task automatic test_wrap_ovf;
    logic [7:0] d;
    bit ok;
    auto_tx = 1'b0; enable = 1'b0; man_busy = 1'b0;
    for (int i = 0; i < 7; i++) push(8'h10 + 8'(i));
    total++;
    if (level !== 4'd7) begin bad++; $display("FAIL wrap_pre_level got=%0d exp=7", level); end
    enable = 1'b1;
    push(8'h17);
    total += 2;
    if (level !== 4'd7) begin bad++; $display("FAIL wrap_level got=%0d exp=7", level); end
    if (tx_data !== 8'h10) begin bad++; $display("FAIL wrap_head got=%h exp=10", tx_data); end
    push(8'h18);
    total += 2;
    if (level !== 4'd8) begin bad++; $display("FAIL wrap_full_level got=%0d exp=8", level); end
    if (full !== 1'b1) begin bad++; $display("FAIL wrap_full got=%b exp=1", full); end
    ovf_clr = 1'b1;
    push(8'h19);
    ovf_clr = 1'b0;
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr_alone got=%b exp=0", overflow); end
    for (int k = 0; k < 9; k++) begin
      man_frame(d, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL wrap_frame%0d timeout got=none exp=%h", k, 8'h10 + 8'(k)); end
      else if (d !== 8'h10 + 8'(k))
        begin bad++; $display("FAIL wrap_frame%0d got=%h exp=%h", k, d, 8'h10 + 8'(k)); end
    end
    total++;
    if (tx_start !== 1'b0) begin bad++; $display("FAIL wrap_fall got=%b exp=0", tx_start); end
    repeat (10) @(negedge clk);
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    bit ok;
    bit launched;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    enable = 1'b1;
    for (int i = 0; i < 20 && !tx_start; i++) @(negedge clk);
    total += 2;
    if (tx_start !== 1'b1) begin bad++; $display("FAIL midrst_launch got=%b exp=1", tx_start); end
    if (level !== 4'd3) begin bad++; $display("FAIL midrst_level_pre got=%0d exp=3", level); end
    rst_n = 1'b0;
    #1;
    total += 3;
    if (tx_start !== 1'b0) begin bad++; $display("FAIL midrst_start got=%b exp=0", tx_start); end
    if (level !== 4'd0) begin bad++; $display("FAIL midrst_level got=%0d exp=0", level); end
    if (empty !== 1'b1) begin bad++; $display("FAIL midrst_empty got=%b exp=1", empty); end
    @(negedge clk);
    rst_n = 1'b1;
    launched = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_start) launched = 1'b1;
    end
    total += 2;
    if (launched) begin bad++; $display("FAIL midrst_quiet got=launch exp=none"); end
    if (level !== 4'd0) begin bad++; $display("FAIL midrst_level_post got=%0d exp=0", level); end
    push(8'h30);
    man_frame(d, ok);
    total++;
    if (!ok || d !== 8'h30) begin bad++; $display("FAIL midrst_new got=%h ok=%0d exp=30", d, ok); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_enable_gap;
    int ss, gs;
    auto_tx = 1'b1; enable = 1'b0;
    push(8'h41);
    push(8'h42);
    ss = sent_q.size(); gs = gap_q.size();
    enable = 1'b1;
    for (int i = 0; i < 20 && !tx_start; i++) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 200 && sent_q.size() < ss + 1; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    total += 4;
    if (sent_q.size() != ss + 1) begin bad++; $display("FAIL en_hold_count got=%0d exp=1", sent_q.size() - ss); end
    if (level !== 4'd1) begin bad++; $display("FAIL en_hold_level got=%0d exp=1", level); end
    if (tx_start !== 1'b0) begin bad++; $display("FAIL en_hold_start got=%b exp=0", tx_start); end
    if (tx_data !== 8'h41) begin bad++; $display("FAIL en_hold_data got=%h exp=41", tx_data); end
    enable = 1'b1;
    for (int i = 0; i < 200 && sent_q.size() < ss + 2; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    total += 3;
    if (sent_q.size() != ss + 2) begin
      bad++; $display("FAIL en_second_count got=%0d exp=2", sent_q.size() - ss);
    end else begin
      if (sent_q[ss] !== 8'h41 || sent_q[ss + 1] !== 8'h42)
        begin bad++; $display("FAIL en_order got=%h,%h exp=41,42", sent_q[ss], sent_q[ss + 1]); end
    end
    if (gap_q.size() < gs + 2 || gap_q[gs + 1] < GAP_CYCLES + 2)
      begin bad++; $display("FAIL en_gap got=%0d exp>=%0d", (gap_q.size() >= gs + 2) ? gap_q[gs + 1] : -1, GAP_CYCLES + 2); end
    if (empty !== 1'b1) begin bad++; $display("FAIL en_empty got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_overflow_order;
    test_wrap_ovf;
    test_reset_midframe;
    test_enable_gap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
